// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared constants, channel code and FSM state types for the DMAC channel arbiter
package dmac_pkg;

   localparam int NUM_CH = 6;

   typedef logic [2:0] dmac_ch_t;

   localparam dmac_ch_t IDLE_CODE = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RELEASE
   } arb_state_t;

   // Modulo-NUM_CH add; both operands are always below NUM_CH.
   function automatic dmac_ch_t ch_add(dmac_ch_t a, dmac_ch_t b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'(NUM_CH)) ? dmac_ch_t'(s - 4'(NUM_CH)) : s[2:0];
   endfunction

endpackage

// File: rtl/dmac_channel_arbiter_rr_pick.sv
// rtl/dmac_channel_arbiter_rr_pick.sv - combinational round-robin picker: first eligible channel at or above ptr, wrapping
module rr_pick
   import dmac_pkg::*;
(
   input  logic [NUM_CH-1:0] eligible,
   input  dmac_ch_t          ptr,
   output logic              found,
   output dmac_ch_t          idx
);

   // Scan from the farthest offset down so the nearest hit overwrites the rest.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (eligible[ch_add(ptr, dmac_ch_t'(i))]) begin
            found = 1'b1;
            idx   = ch_add(ptr, dmac_ch_t'(i));
         end
      end
   end

endmodule

// File: rtl/dmac_channel_arbiter.sv
// rtl/dmac_channel_arbiter.sv - round-robin DMA channel arbiter holding each grant until TransferDone
module dmac_channel_arbiter
   import dmac_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] ChannelRequest,
   input  logic [NUM_CH-1:0] ChannelEnable,
   input  logic [NUM_CH-1:0] ChannelFIFOEmpty,
   input  logic [NUM_CH-1:0] ChannelFIFOFull,
   input  logic              TransferDone,
   output logic [2:0]        DMACActivedChannel,
   output logic              ChannelActive,
   output logic [NUM_CH-1:0] ChannelGrant,
   output logic [NUM_CH-1:0] ChannelAck,
   output logic              ActiveFIFOEmpty,
   output logic              ActiveFIFOFull,
   output logic              TimeoutError
);

   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   arb_state_t        state_q, state_d;
   dmac_ch_t          ptr_q, ptr_d;
   dmac_ch_t          code_q, code_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic              active_q, active_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic              pick_found;
   dmac_ch_t          pick_idx;

`ifdef DMAC_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tout_q, tout_d;
`endif

   rr_pick u_pick (
      .eligible (ChannelRequest & ChannelEnable),
      .ptr      (ptr_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      code_d   = code_q;
      grant_d  = grant_q;
      active_d = active_q;
      ack_d    = '0;
`ifdef DMAC_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      tout_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d  = ST_GRANT;
               code_d   = pick_idx;
               grant_d  = ONE_HOT0 << pick_idx;
               active_d = 1'b1;
`ifdef DMAC_ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         ST_GRANT: begin
`ifdef DMAC_ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            // Done wins over a simultaneous watchdog expiry.
            if (TransferDone) begin
               state_d  = ST_RELEASE;
               ack_d    = grant_q;
               ptr_d    = ch_add(code_q, dmac_ch_t'(1));
               code_d   = IDLE_CODE;
               grant_d  = '0;
               active_d = 1'b0;
            end
`ifdef DMAC_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d  = ST_RELEASE;
               tout_d   = 1'b1;
               ptr_d    = ch_add(code_q, dmac_ch_t'(1));
               code_d   = IDLE_CODE;
               grant_d  = '0;
               active_d = 1'b0;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         code_q   <= IDLE_CODE;
         grant_q  <= '0;
         active_q <= 1'b0;
         ack_q    <= '0;
`ifdef DMAC_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         tout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         code_q   <= code_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         ack_q    <= ack_d;
`ifdef DMAC_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
`endif
      end
   end

   assign DMACActivedChannel = code_q;
   assign ChannelActive      = active_q;
   assign ChannelGrant       = grant_q;
   assign ChannelAck         = ack_q;
   assign ActiveFIFOEmpty    = active_q ? ChannelFIFOEmpty[code_q] : 1'b1;
   assign ActiveFIFOFull     = active_q ? ChannelFIFOFull[code_q]  : 1'b0;
`ifdef DMAC_ARB_TIMEOUT_EN
   assign TimeoutError       = tout_q;
`else
   assign TimeoutError       = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// tb/tb_dmac_channel_arbiter.sv - self-checking bench: behavioural arbiter model plus directed scenarios
module tb_dmac_channel_arbiter;

   logic       Clk;
   logic       Reset;
   logic [5:0] ChannelRequest;
   logic [5:0] ChannelEnable;
   logic [5:0] ChannelFIFOEmpty;
   logic [5:0] ChannelFIFOFull;
   logic       TransferDone;
   logic [2:0] DMACActivedChannel;
   logic       ChannelActive;
   logic [5:0] ChannelGrant;
   logic [5:0] ChannelAck;
   logic       ActiveFIFOEmpty;
   logic       ActiveFIFOFull;
   logic       TimeoutError;

   int checks;
   int failures;

   localparam int TMO = 8;

   dmac_channel_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .Clk                (Clk),
      .Reset              (Reset),
      .ChannelRequest     (ChannelRequest),
      .ChannelEnable      (ChannelEnable),
      .ChannelFIFOEmpty   (ChannelFIFOEmpty),
      .ChannelFIFOFull    (ChannelFIFOFull),
      .TransferDone       (TransferDone),
      .DMACActivedChannel (DMACActivedChannel),
      .ChannelActive      (ChannelActive),
      .ChannelGrant       (ChannelGrant),
      .ChannelAck         (ChannelAck),
      .ActiveFIFOEmpty    (ActiveFIFOEmpty),
      .ActiveFIFOFull     (ActiveFIFOFull),
      .TimeoutError       (TimeoutError)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 waiting, 1 holding channel m_ch, 2 releasing; m_age counts cycles held.
   int         m_phase, m_ptr, m_ch, m_age;
   int         glog[$];
   logic [5:0] m_elig;
   logic [2:0] e_code;
   logic [5:0] e_grant, e_ack;
   logic       e_active, e_tout;
   bit         started;

   always @(posedge Clk) begin
      started = 1'b1;
      e_ack   = '0;
      e_tout  = 1'b0;
      if (Reset) begin
         m_phase = 0; m_ptr = 0; m_age = 0;
         e_code = 3'b111; e_grant = '0; e_active = 1'b0;
      end else if (m_phase == 0) begin
         m_elig = ChannelRequest & ChannelEnable;
         for (int k = 0; k < 6; k++) begin
            if (m_phase == 0 && m_elig[(m_ptr + k) % 6]) begin
               m_ch = (m_ptr + k) % 6; m_phase = 1; m_age = 0;
               glog.push_back(m_ch);
            end
         end
         if (m_phase == 1) begin
            e_code = 3'(m_ch); e_grant = 6'(1 << m_ch); e_active = 1'b1;
         end
      end else if (m_phase == 1) begin
         m_age++;
         if (TransferDone) begin
            e_ack = 6'(1 << m_ch);
            m_ptr = (m_ch + 1) % 6; m_phase = 2;
            e_code = 3'b111; e_grant = '0; e_active = 1'b0;
         end
`ifdef DMAC_ARB_TIMEOUT_EN
         else if (m_age == TMO) begin
            e_tout = 1'b1;
            m_ptr = (m_ch + 1) % 6; m_phase = 2;
            e_code = 3'b111; e_grant = '0; e_active = 1'b0;
         end
`endif
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge Clk) begin
      if (started) begin
         chk("model_code",   32'(DMACActivedChannel), 32'(e_code));
         chk("model_grant",  32'(ChannelGrant),       32'(e_grant));
         chk("model_active", 32'(ChannelActive),      32'(e_active));
         chk("model_ack",    32'(ChannelAck),         32'(e_ack));
         chk("model_tout",   32'(TimeoutError),       32'(e_tout));
         chk("model_fempty", 32'(ActiveFIFOEmpty), 32'(e_active ? ChannelFIFOEmpty[m_ch] : 1'b1));
         chk("model_ffull",  32'(ActiveFIFOFull),  32'(e_active ? ChannelFIFOFull[m_ch]  : 1'b0));
      end
   end

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic do_reset();
      Reset = 1'b1; step(); step(); Reset = 1'b0;
   endtask

   task automatic done_pulse();
      TransferDone = 1'b1; step(); TransferDone = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "time limit");
   end

   int got[$];
   int n;

   initial begin
      checks = 0; failures = 0;
      Reset = 1'b1; ChannelRequest = '0; ChannelEnable = 6'h3f;
      ChannelFIFOEmpty = 6'b101010; ChannelFIFOFull = 6'b010101; TransferDone = 1'b0;
      do_reset();
      chk("rst_code",   32'(DMACActivedChannel), 32'h7);
      chk("rst_grant",  32'(ChannelGrant), 32'h0);
      chk("rst_active", 32'(ChannelActive), 32'h0);
      chk("rst_ack",    32'(ChannelAck), 32'h0);
      chk("rst_fempty", 32'(ActiveFIFOEmpty), 32'h1);
      chk("rst_ffull",  32'(ActiveFIFOFull), 32'h0);

      // Single request on channel 2
      ChannelRequest = 6'b000100; step(); ChannelRequest = '0;
      chk("t1_code",   32'(DMACActivedChannel), 32'h2);
      chk("t1_grant",  32'(ChannelGrant), 32'h04);
      chk("t1_fempty", 32'(ActiveFIFOEmpty), 32'h0);
      chk("t1_ffull",  32'(ActiveFIFOFull), 32'h1);
      step();
      chk("t1_hold", 32'(DMACActivedChannel), 32'h2);
      done_pulse();
      chk("t1_ack",      32'(ChannelAck), 32'h04);
      chk("t1_rel_code", 32'(DMACActivedChannel), 32'h7);
      step();
      chk("t1_ack_off", 32'(ChannelAck), 32'h0);

      // All six requesting: order must wrap 5->0
      do_reset();
      ChannelRequest = 6'h3f;
      for (int g = 0; g < 7; g++) begin
         n = 0;
         while (!ChannelActive && n < 10) begin step(); n++; end
         if (!ChannelActive) chk("t2_wait_grant", 32'(ChannelActive), 32'h1);
         got.push_back(int'(DMACActivedChannel));
         done_pulse(); step();
      end
      ChannelRequest = '0; step(); step();
      for (int g = 0; g < 7; g++)
         chk($sformatf("t2_order_%0d", g), 32'(got[g]), 32'(g % 6));

      // Disabled channel 3 never granted
      do_reset();
      ChannelEnable = 6'b110111; ChannelRequest = 6'b001000;
      for (int i = 0; i < 10; i++) step();
      chk("t3_code",   32'(DMACActivedChannel), 32'h7);
      chk("t3_active", 32'(ChannelActive), 32'h0);
      ChannelRequest = '0; ChannelEnable = 6'h3f;

      // Grant held on 1 while request drops and 4 requests; 4 granted at M+3
      do_reset();
      ChannelRequest = 6'b000010; step();
      chk("t4_grant1", 32'(DMACActivedChannel), 32'h1);
      ChannelRequest = 6'b010000;
      for (int i = 0; i < 3; i++) step();
      chk("t4_held", 32'(DMACActivedChannel), 32'h1);
      done_pulse();
      chk("t4_m1_ack",  32'(ChannelAck), 32'h02);
      step();
      chk("t4_m2_idle", 32'(ChannelActive), 32'h0);
      step();
      chk("t4_m3_code",  32'(DMACActivedChannel), 32'h4);
      chk("t4_m3_grant", 32'(ChannelGrant), 32'h10);
      ChannelRequest = '0; done_pulse(); step();

      // Reset mid-grant on 5, then channel 0 wins because the pointer is back at 0
      do_reset();
      ChannelRequest = 6'b100000; step();
      chk("t5_grant5", 32'(DMACActivedChannel), 32'h5);
      Reset = 1'b1; step(); Reset = 1'b0;
      chk("t5_rst_code", 32'(DMACActivedChannel), 32'h7);
      chk("t5_rst_ack",  32'(ChannelAck), 32'h0);
      ChannelRequest = 6'b100001; step();
      chk("t5_grant0", 32'(DMACActivedChannel), 32'h0);
      ChannelRequest = '0; done_pulse(); step();

`ifdef DMAC_ARB_TIMEOUT_EN
      // Watchdog: no TransferDone, error pulse 8 cycles after grant
      do_reset();
      ChannelRequest = 6'b000001; step(); ChannelRequest = '0;
      chk("t6_grant", 32'(ChannelActive), 32'h1);
      for (int i = 0; i < TMO - 1; i++) step();
      chk("t6_still", 32'(ChannelActive), 32'h1);
      chk("t6_no_err", 32'(TimeoutError), 32'h0);
      step();
      chk("t6_err",    32'(TimeoutError), 32'h1);
      chk("t6_no_ack", 32'(ChannelAck), 32'h0);
      chk("t6_code",   32'(DMACActivedChannel), 32'h7);
      step();
      chk("t6_err_off", 32'(TimeoutError), 32'h0);
      ChannelRequest = 6'b000011; step(); ChannelRequest = '0;
      chk("t6_ptr_adv", 32'(DMACActivedChannel), 32'h1);
      done_pulse(); step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
